// File: rtl/ctu_rst_seq_pkg.sv
// ctu_rst_seq_pkg: shared types, defaults and width helper for the CTU cluster reset sequencer
package ctu_rst_seq_pkg;
    typedef enum logic [2:0] {RAMP, HOLD, RUN, WRM, DBG} seq_state_e;
    localparam int DEF_NUM_CLUSTERS = 4;
    localparam int DEF_STAGGER_CYC  = 4;
    localparam int DEF_RST_HOLD_CYC = 16;
    localparam int DEF_DBG_HOLD_CYC = 8;
    function automatic int seq_w(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        m = (m > c) ? m : c;
        return (m < 1) ? 1 : $clog2(m + 1);
    endfunction
endpackage

// File: rtl/ctu_rst_seq_timer.sv
// ctu_rst_seq_timer: loadable down-counter that stops at zero and flags it
// Ports: gclk, arst (async, active-high), load + load_val (reload), zero (count is zero)
module ctu_rst_seq_timer #(
    parameter int W = 4
) (
    input  logic         gclk,
    input  logic         arst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         zero
);
    logic [W-1:0] cnt;
    always_ff @(posedge gclk or posedge arst)
        if (arst) cnt <= '0;
        else if (load) cnt <= load_val;
        else if (cnt != '0) cnt <= cnt - 1'b1;
    assign zero = cnt == '0;
endmodule

// File: rtl/ctu_cluster_rst_seq.sv
// ctu_cluster_rst_seq: staggers cluster clock enables, then sequences global reset and debug-init
// Ports: gclk, arst (async, active-high); wrm_rst_req, dbginit_req (1-cycle requests);
//   cken_mask (per-cluster clock permit); cluster_cken, grst_l, gdbginit_l (to headers);
//   seq_busy (state != RUN), seq_done (pulse on entry to RUN).
// Optional: define CTU_RST_SEQ_WRMCNT_EN to add wrm_rst_cnt, a saturating count of accepted warm resets.
module ctu_cluster_rst_seq
    import ctu_rst_seq_pkg::*;
#(
    parameter int NUM_CLUSTERS = DEF_NUM_CLUSTERS,
    parameter int STAGGER_CYC  = DEF_STAGGER_CYC,
    parameter int RST_HOLD_CYC = DEF_RST_HOLD_CYC,
    parameter int DBG_HOLD_CYC = DEF_DBG_HOLD_CYC
) (
    input  logic                    gclk,
    input  logic                    arst,
    input  logic                    wrm_rst_req,
    input  logic                    dbginit_req,
    input  logic [NUM_CLUSTERS-1:0] cken_mask,
    output logic [NUM_CLUSTERS-1:0] cluster_cken,
    output logic                    grst_l,
    output logic                    gdbginit_l,
    output logic                    seq_busy,
    output logic                    seq_done
`ifdef CTU_RST_SEQ_WRMCNT_EN
    ,
    output logic [7:0]              wrm_rst_cnt
`endif
);
    localparam int TW = seq_w(RST_HOLD_CYC, DBG_HOLD_CYC, STAGGER_CYC);
    localparam int IW = seq_w(NUM_CLUSTERS - 1, 1, 1);
    seq_state_e              state, state_nx;
    logic [IW-1:0]           idx;
    logic [NUM_CLUSTERS-1:0] ramp_en, ramp_nx;
    logic                    tmr_zero, tmr_load, last;
    logic [TW-1:0]           tmr_val;
    assign last = idx == IW'(NUM_CLUSTERS - 1);
    // Timer loads are one short of the hold length: the expiry edge is the one that sees zero.
    always_comb begin
        state_nx = state;
        case (state)
            RAMP:    state_nx = (tmr_zero && last) ? HOLD : RAMP;
            HOLD:    state_nx = tmr_zero ? RUN : HOLD;
            RUN:     state_nx = wrm_rst_req ? WRM : dbginit_req ? DBG : RUN;
            WRM:     state_nx = tmr_zero ? RUN : WRM;
            DBG:     state_nx = wrm_rst_req ? WRM : tmr_zero ? RUN : DBG;
            default: state_nx = RAMP;
        endcase
        ramp_nx  = (state == RAMP && tmr_zero) ? ramp_en | (NUM_CLUSTERS'(1) << idx) : ramp_en;
        tmr_load = (state == RAMP && tmr_zero) || (state_nx == WRM && state != WRM) ||
                   (state_nx == DBG && state != DBG);
        tmr_val  = (state_nx == HOLD || state_nx == WRM) ? TW'(RST_HOLD_CYC - 1) :
                   (state_nx == DBG) ? TW'(DBG_HOLD_CYC - 1) : TW'(STAGGER_CYC - 1);
    end
    ctu_rst_seq_timer #(.W(TW)) u_timer (
        .gclk     (gclk),
        .arst     (arst),
        .load     (tmr_load),
        .load_val (tmr_val),
        .zero     (tmr_zero)
    );
    always_ff @(posedge gclk or posedge arst)
        if (arst) begin
            state        <= RAMP;
            idx          <= '0;
            ramp_en      <= '0;
            cluster_cken <= '0;
            grst_l       <= 1'b0;
            gdbginit_l   <= 1'b0;
            seq_busy     <= 1'b1;
            seq_done     <= 1'b0;
`ifdef CTU_RST_SEQ_WRMCNT_EN
            wrm_rst_cnt  <= '0;
`endif
        end else begin
            state        <= state_nx;
            idx          <= (state == RAMP && tmr_zero && !last) ? idx + 1'b1 : idx;
            ramp_en      <= ramp_nx;
            cluster_cken <= ramp_nx & cken_mask;
            grst_l       <= state_nx == RUN || state_nx == DBG;
            gdbginit_l   <= state_nx == RUN;
            seq_busy     <= state_nx != RUN;
            seq_done     <= state_nx == RUN && state != RUN;
`ifdef CTU_RST_SEQ_WRMCNT_EN
            wrm_rst_cnt  <= (state_nx == WRM && state != WRM && wrm_rst_cnt != 8'hFF) ?
                            wrm_rst_cnt + 8'd1 : wrm_rst_cnt;
`endif
        end
endmodule

// File: tb/tb_ctu_cluster_rst_seq.sv
// tb_ctu_cluster_rst_seq: directed checks of ramp, hold, warm reset, debug-init, mask and async reset
module tb_ctu_cluster_rst_seq;
    logic       gclk = 1'b0;
    logic       arst = 1'b1;
    logic       wrm_rst_req = 1'b0;
    logic       dbginit_req = 1'b0;
    logic [3:0] cken_mask = 4'hF;
    logic [3:0] cluster_cken;
    logic       grst_l, gdbginit_l, seq_busy, seq_done;
    logic [7:0] o;
    int         total = 0;
    int         bad = 0;
`ifdef CTU_RST_SEQ_WRMCNT_EN
    logic [7:0] wrm_rst_cnt;
`endif
    localparam logic [7:0] RUNW = 8'hFC, WRMW = 8'hF2, DBGW = 8'hFA, DONEW = 8'hFD, RSTW = 8'h02;
    ctu_cluster_rst_seq dut (
        .gclk         (gclk),
        .arst         (arst),
        .wrm_rst_req  (wrm_rst_req),
        .dbginit_req  (dbginit_req),
        .cken_mask    (cken_mask),
        .cluster_cken (cluster_cken),
        .grst_l       (grst_l),
        .gdbginit_l   (gdbginit_l),
        .seq_busy     (seq_busy),
        .seq_done     (seq_done)
`ifdef CTU_RST_SEQ_WRMCNT_EN
        ,
        .wrm_rst_cnt  (wrm_rst_cnt)
`endif
    );
    always #5 gclk = ~gclk;
    assign o = {cluster_cken, grst_l, gdbginit_l, seq_busy, seq_done};
    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask
    task automatic tick;
        @(posedge gclk);
        #1;
    endtask
    task automatic hold_chk(input string tag, input int n, input logic [7:0] exp);
        for (int j = 0; j < n; j++) begin
            tick();
            chk($sformatf("%s%0d", tag, j), o, exp);
        end
    endtask
    // Ramp from reset release; k is the edge number. inj pokes requests during HOLD.
    task automatic ramp_run(input string tag, input logic [3:0] m, input logic inj);
        logic [3:0] ck;
        for (int k = 0; k <= 28; k++) begin
            dbginit_req = inj && k == 18;
            wrm_rst_req = inj && k == 20;
            tick();
            dbginit_req = 1'b0;
            wrm_rst_req = 1'b0;
            ck = '0;
            for (int i = 0; i < 4; i++) if (i * 4 <= k) ck[i] = 1'b1;
            chk($sformatf("%s%0d", tag, k), o,
                {ck & m, k >= 28 ? 1'b1 : 1'b0, k >= 28 ? 1'b1 : 1'b0, k < 28 ? 1'b1 : 1'b0, k == 28 ? 1'b1 : 1'b0});
        end
    endtask
    initial begin
        tick();
        tick();
        chk("rst", o, RSTW);
        arst = 1'b0;
        ramp_run("ramp", 4'hF, 1'b0);
        hold_chk("run", 2, RUNW);
        wrm_rst_req = 1'b1;
        tick();
        wrm_rst_req = 1'b0;
        chk("wrm0", o, WRMW);
        hold_chk("wrm", 15, WRMW);
        hold_chk("wrm_done", 1, DONEW);
        hold_chk("wrm_run", 1, RUNW);
`ifdef CTU_RST_SEQ_WRMCNT_EN
        chk("cnt1", wrm_rst_cnt, 8'd1);
`endif
        dbginit_req = 1'b1;
        tick();
        dbginit_req = 1'b0;
        chk("dbg0", o, DBGW);
        hold_chk("dbg", 7, DBGW);
        hold_chk("dbg_done", 1, DONEW);
        hold_chk("dbg_run", 1, RUNW);
        dbginit_req = 1'b1;
        tick();
        dbginit_req = 1'b0;
        hold_chk("pdbg", 2, DBGW);
        wrm_rst_req = 1'b1;
        tick();
        wrm_rst_req = 1'b0;
        chk("prom0", o, WRMW);
        hold_chk("prom", 15, WRMW);
        hold_chk("prom_done", 1, DONEW);
        hold_chk("prom_run", 1, RUNW);
        wrm_rst_req = 1'b1;
        dbginit_req = 1'b1;
        tick();
        wrm_rst_req = 1'b0;
        dbginit_req = 1'b0;
        chk("both0", o, WRMW);
        hold_chk("both", 4, WRMW);
        dbginit_req = 1'b1;
        wrm_rst_req = 1'b1;
        tick();
        dbginit_req = 1'b0;
        wrm_rst_req = 1'b0;
        chk("wrm_ign", o, WRMW);
        hold_chk("both_b", 10, WRMW);
        hold_chk("both_done", 1, DONEW);
        hold_chk("both_run", 1, RUNW);
`ifdef CTU_RST_SEQ_WRMCNT_EN
        chk("cnt3", wrm_rst_cnt, 8'd3);
`endif
        wrm_rst_req = 1'b1;
        tick();
        wrm_rst_req = 1'b0;
        hold_chk("mid", 3, WRMW);
        #2 arst = 1'b1;
        #1 chk("arst_now", o, RSTW);
        tick();
        chk("arst_hold", o, RSTW);
        cken_mask = 4'b1010;
        arst = 1'b0;
`ifdef CTU_RST_SEQ_WRMCNT_EN
        chk("cnt_rst", wrm_rst_cnt, 8'd0);
`endif
        ramp_run("mramp", 4'b1010, 1'b1);
        hold_chk("mrun", 1, 8'hAC);
        cken_mask = 4'hF;
        hold_chk("mask_f", 1, RUNW);
`ifdef CTU_RST_SEQ_WRMCNT_EN
        for (int n = 0; n < 300; n++) begin
            wrm_rst_req = 1'b1;
            tick();
            wrm_rst_req = 1'b0;
            repeat (16) tick();
        end
        chk("cnt_sat", wrm_rst_cnt, 8'hFF);
        chk("cnt_run", o, RUNW);
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
